// File: rtl/instruction_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_pkg
// Description : Shared definitions for the decode stage: data/PC widths,
//               opcode and ALU codes, instruction field positions, the
//               control-word type and the opcode decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

    // Default widths
    localparam int DATA_W  = 16;
    localparam int PC_W    = 16;
    localparam int NREGS   = 16;
    localparam int REG_AW  = 4;
    localparam int INSTR_W = 32;
    localparam int OPC_W   = 6;
    localparam int ALU_W   = 4;

    // Instruction field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 22;
    localparam int RS1_MSB = 21;
    localparam int RS1_LSB = 18;
    localparam int RS2_MSB = 17;
    localparam int RS2_LSB = 14;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Opcodes
    localparam logic [OPC_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OPC_W-1:0] OP_ADD   = 6'd1;
    localparam logic [OPC_W-1:0] OP_SUB   = 6'd2;
    localparam logic [OPC_W-1:0] OP_AND   = 6'd3;
    localparam logic [OPC_W-1:0] OP_OR    = 6'd4;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'd5;
    localparam logic [OPC_W-1:0] OP_LOAD  = 6'd6;
    localparam logic [OPC_W-1:0] OP_STORE = 6'd7;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'd8;
    localparam logic [OPC_W-1:0] OP_JMP   = 6'd9;
    localparam logic [OPC_W-1:0] OP_HALT  = 6'd63;

    // ALU operation codes
    localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;

    typedef struct packed {
        logic [ALU_W-1:0] alu_op;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             jump;
        logic             use_imm;
        logic             halt;
        logic             illegal;
    } ctrl_t;

    // Control word for an opcode; unknown opcodes only raise illegal.
    function automatic ctrl_t decode_ctrl(input logic [OPC_W-1:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_NOP:   ;
            OP_ADD:   begin c.reg_write = 1'b1; c.alu_op = ALU_ADD; end
            OP_SUB:   begin c.reg_write = 1'b1; c.alu_op = ALU_SUB; end
            OP_AND:   begin c.reg_write = 1'b1; c.alu_op = ALU_AND; end
            OP_OR:    begin c.reg_write = 1'b1; c.alu_op = ALU_OR;  end
            OP_ADDI:  begin c.reg_write = 1'b1; c.use_imm = 1'b1; end
            OP_LOAD:  begin c.reg_write = 1'b1; c.use_imm = 1'b1; c.mem_read = 1'b1; end
            OP_STORE: begin c.use_imm = 1'b1; c.mem_write = 1'b1; end
            OP_BEQ:   begin c.branch = 1'b1; c.alu_op = ALU_SUB; end
            OP_JMP:   c.jump = 1'b1;
            OP_HALT:  c.halt = 1'b1;
            default:  c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // Opcodes whose rs2 field names a real source register (not imm bits).
    function automatic logic uses_rs2(input logic [OPC_W-1:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) ||
               (opcode == OP_OR)  || (opcode == OP_STORE) || (opcode == OP_BEQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_decode_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decode_if
// Description : Bundle between fetch/write-back/execute and the decode stage.
//               master : environment side (drives fetch, flush, write-back)
//               slave  : decode stage (drives stall_out and the ID/EX outputs)
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_decode_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
);
    // fetch side
    logic              if_valid;
    logic [31:0]       if_instruction;
    logic [PC_W-1:0]   if_pc;
    logic              stall_out;
    // execute / write-back side
    logic              flush;
    logic              wb_en;
    logic [3:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    // ID/EX boundary
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [3:0]        id_rd;
    logic [DATA_W-1:0] id_rs1_data;
    logic [DATA_W-1:0] id_rs2_data;
    logic [DATA_W-1:0] id_imm;
    logic [3:0]        id_alu_op;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_branch;
    logic              id_jump;
    logic              id_use_imm;
    logic              id_halt;
    logic              id_illegal;

    modport master (
        output if_valid, if_instruction, if_pc, flush, wb_en, wb_addr, wb_data,
        input  stall_out, id_valid, id_pc, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
               id_branch, id_jump, id_use_imm, id_halt, id_illegal
    );

    modport slave (
        input  if_valid, if_instruction, if_pc, flush, wb_en, wb_addr, wb_data,
        output stall_out, id_valid, id_pc, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
               id_branch, id_jump, id_use_imm, id_halt, id_illegal
    );
endinterface
`default_nettype wire

// File: rtl/instruction_decode_register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : NREGS x DATA_W register file, 1 write port, 2 combinational
//               read ports with write-through bypass. r0 is hard-wired zero.
// Ports       : clk, rst_n         - clock, async active-low reset
//               wr_en/addr/data    - write port (edge-triggered)
//               rd_addr_a/b        - read addresses
//               rd_data_a/b        - read data (bypassed from write port)
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] w_rf [NREGS];

    assign w_rf[0] = '0;

    generate
        for (genvar i = 1; i < NREGS; i++) begin : g_reg
            logic [DATA_W-1:0] r_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (wr_en && (wr_addr == AW'(i))) begin
                    r_q <= wr_data;
                end
            end

            assign w_rf[i] = r_q;
        end
    endgenerate

    // A write in flight is visible to a same-cycle read; r0 never bypasses.
    assign rd_data_a = (wr_en && (wr_addr == rd_addr_a) && (rd_addr_a != '0))
                       ? wr_data : w_rf[rd_addr_a];
    assign rd_data_b = (wr_en && (wr_addr == rd_addr_b) && (rd_addr_b != '0))
                       ? wr_data : w_rf[rd_addr_b];

endmodule
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decode
// Description : ID pipeline stage. Holds the IF/ID register, decodes the
//               32-bit instruction, reads operands from the register file,
//               detects load-use hazards and registers the ID/EX boundary.
// Ports       : clk, rst_n - clock, async active-low reset
//               bus (slave) - fetch inputs + stall_out, flush, write-back
//                             port, and the registered id_* outputs
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_decode #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int NREGS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instruction_decode_if.slave  bus
);
    import risc_pkg::*;

    // IF/ID register
    logic               r_ifid_valid;
    logic [INSTR_W-1:0] r_ifid_instr;
    logic [PC_W-1:0]    r_ifid_pc;

    // Decode of the IF/ID contents
    logic [OPC_W-1:0]   w_opcode;
    logic [REG_AW-1:0]  w_rd;
    logic [REG_AW-1:0]  w_rs1;
    logic [REG_AW-1:0]  w_rs2;
    logic [DATA_W-1:0]  w_imm;
    logic [DATA_W-1:0]  w_rs1_data;
    logic [DATA_W-1:0]  w_rs2_data;
    ctrl_t              w_ctrl;
    ctrl_t              w_ctrl_gated;
    logic [REG_AW-1:0]  w_dec_rd;
    logic               w_stall;

    // ID/EX register
    logic               r_id_valid;
    logic [PC_W-1:0]    r_id_pc;
    logic [REG_AW-1:0]  r_id_rd;
    logic [DATA_W-1:0]  r_id_rs1_data;
    logic [DATA_W-1:0]  r_id_rs2_data;
    logic [DATA_W-1:0]  r_id_imm;
    ctrl_t              r_id_ctrl;

    assign w_opcode = r_ifid_instr[OPC_MSB:OPC_LSB];
    assign w_rd     = r_ifid_instr[RD_MSB:RD_LSB];
    assign w_rs1    = r_ifid_instr[RS1_MSB:RS1_LSB];
    assign w_rs2    = r_ifid_instr[RS2_MSB:RS2_LSB];
    assign w_imm    = DATA_W'(r_ifid_instr[IMM_MSB:IMM_LSB]);

    always_comb begin
        w_ctrl       = decode_ctrl(w_opcode);
        // An empty slot must present no control activity downstream.
        w_ctrl_gated = r_ifid_valid ? w_ctrl : '0;
        w_dec_rd     = w_ctrl.illegal ? '0 : w_rd;
    end

    // Load-use: the load in ID/EX has not produced data yet, so the consumer
    // sitting in IF/ID must wait one cycle. rs2 only counts when it is a real
    // register operand rather than immediate bits.
    assign w_stall = r_ifid_valid && r_id_valid && r_id_ctrl.mem_read &&
                     (r_id_rd != '0) &&
                     ((r_id_rd == w_rs1) ||
                      ((r_id_rd == w_rs2) && uses_rs2(w_opcode)));

    register_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (REG_AW)
    ) u_register_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (bus.wb_en),
        .wr_addr   (bus.wb_addr),
        .wr_data   (bus.wb_data),
        .rd_addr_a (w_rs1),
        .rd_data_a (w_rs1_data),
        .rd_addr_b (w_rs2),
        .rd_data_b (w_rs2_data)
    );

    // IF/ID: flush wins over stall; a stall simply holds the current slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
        end else if (bus.flush) begin
            r_ifid_valid <= 1'b0;
        end else if (!w_stall) begin
            r_ifid_valid <= bus.if_valid;
            r_ifid_instr <= bus.if_instruction;
            r_ifid_pc    <= bus.if_pc;
        end
    end

    // ID/EX: a flush or a stall inserts a fully cleared bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid    <= 1'b0;
            r_id_pc       <= '0;
            r_id_rd       <= '0;
            r_id_rs1_data <= '0;
            r_id_rs2_data <= '0;
            r_id_imm      <= '0;
            r_id_ctrl     <= '0;
        end else if (bus.flush || w_stall) begin
            r_id_valid    <= 1'b0;
            r_id_pc       <= '0;
            r_id_rd       <= '0;
            r_id_rs1_data <= '0;
            r_id_rs2_data <= '0;
            r_id_imm      <= '0;
            r_id_ctrl     <= '0;
        end else begin
            r_id_valid    <= r_ifid_valid;
            r_id_pc       <= r_ifid_pc;
            r_id_rd       <= w_dec_rd;
            r_id_rs1_data <= w_rs1_data;
            r_id_rs2_data <= w_rs2_data;
            r_id_imm      <= w_imm;
            r_id_ctrl     <= w_ctrl_gated;
        end
    end

    assign bus.stall_out    = w_stall;
    assign bus.id_valid     = r_id_valid;
    assign bus.id_pc        = r_id_pc;
    assign bus.id_rd        = r_id_rd;
    assign bus.id_rs1_data  = r_id_rs1_data;
    assign bus.id_rs2_data  = r_id_rs2_data;
    assign bus.id_imm       = r_id_imm;
    assign bus.id_alu_op    = r_id_ctrl.alu_op;
    assign bus.id_reg_write = r_id_ctrl.reg_write;
    assign bus.id_mem_read  = r_id_ctrl.mem_read;
    assign bus.id_mem_write = r_id_ctrl.mem_write;
    assign bus.id_branch    = r_id_ctrl.branch;
    assign bus.id_jump      = r_id_ctrl.jump;
    assign bus.id_use_imm   = r_id_ctrl.use_imm;
    assign bus.id_halt      = r_id_ctrl.halt;
    assign bus.id_illegal   = r_id_ctrl.illegal;

endmodule
`default_nettype wire
